// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned N_REQ_MAX = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

  function automatic logic [N_REQ_MAX-1:0] onehot(input int idx);
    logic [N_REQ_MAX-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(N_REQ_MAX); i++) begin
      oh[i] = (i == idx);
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit strictly after last_i, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Upper segment (above last) has priority over the wrapped lower segment.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!valid_o && req_i[i] && (i > int'(last_i))) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!valid_o && req_i[i] && (i <= int'(last_i))) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; NACKed writes are retried.
// Optional per-requester statistics counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned STAT_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [N_REQ-1:0]            done_o,
  output logic                        busy_o,
  output logic                        fifo_wr_en_o,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in_o,
  input  logic                        fifo_full_i,
  input  logic                        fifo_wr_ack_i,
  output logic [N_REQ*STAT_W-1:0]     stat_acc_o,
  output logic [STAT_W-1:0]           stat_retry_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                state_q;
  logic [N_REQ-1:0]      grant_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  wr_en_q;
  logic [IDX_W-1:0]      last_q;
  logic [IDX_W-1:0]      idx_q;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [FIFO_WIDTH-1:0] pick_data;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (int'(pick_idx) == i) begin
        pick_data = req_data_i[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid && !fifo_full_i) begin
            grant_q <= N_REQ'(onehot(int'(pick_idx)));
            data_q  <= pick_data;
            idx_q   <= pick_idx;
            wr_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wr_en_q <= 1'b0;
          state_q <= ACK;
        end
        ACK: begin
          // Pointer moves only on success, so a NACKed requester wins the retry.
          if (fifo_wr_ack_i) begin
            last_q <= idx_q;
          end
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_data_in_o = data_q;
  assign busy_o         = (state_q != IDLE);
  // Reset in the ACK cycle abandons the write, so done is suppressed.
  assign done_o = (state_q == ACK && fifo_wr_ack_i && !rst_i) ? grant_q : '0;

`ifdef FIFO_ARB_STATS_EN
  logic                         nack;
  logic [N_REQ-1:0][STAT_W-1:0] acc_q;
  logic [STAT_W-1:0]            retry_q;

  assign nack = (state_q == ACK) && !fifo_wr_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      retry_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (done_o[i] && (acc_q[i] != '1)) begin
          acc_q[i] <= acc_q[i] + 1'b1;
        end
      end
      if (nack && (retry_q != '1)) begin
        retry_q <= retry_q + 1'b1;
      end
    end
  end

  assign stat_acc_o   = acc_q;
  assign stat_retry_o = retry_q;
`else
  assign stat_acc_o   = '0;
  assign stat_retry_o = '0;
`endif

endmodule
